rbcp_reg_responder: RTL and testbench
=====================================

Name: rbcp_reg_responder

Overview:
- RBCP slave (responder) for the SiTCP core's RBCP initiator port. Decodes RBCP_ADDR/WE/RE, serves a bank of host-writable 8-bit control registers and a bank of read-only status bytes, and returns RBCP_ACK/RBCP_RD.
- Sits in the system top beside the SiTCP instance on the same clock (sys_clk). Control registers fan out to user logic.

Parameters:
- BASE_ADDR, 32'h0000_0000, RBCP base address of this block's window.
- NUM_REGS, 16, number of RW control registers at offsets 0..NUM_REGS-1 (1..128).
- NUM_STAT, 8, number of RO status bytes at offsets STAT_OFFSET..STAT_OFFSET+NUM_STAT-1 (1..128).
- RESET_VAL, {NUM_REGS{8'h00}}, flat NUM_REGS*8 reset image of the control registers.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- RBCP_ACT  in  1  RBCP transaction active.
- RBCP_ADDR  in  32  access address.
- RBCP_WD  in  8  write data.
- RBCP_WE  in  1  write strobe, one-cycle pulse.
- RBCP_RE  in  1  read strobe, one-cycle pulse.
- RBCP_ACK  out  1  access acknowledge, one-cycle pulse.
- RBCP_RD  out  8  read data, valid while RBCP_ACK=1.
- REG_OUT  out  NUM_REGS*8  control registers, reg i at [8i+7:8i].
- STAT_IN  in  NUM_STAT*8  status bytes, byte j at [8j+7:8j]. Sampled at access time.
- REG_WSTB  out  NUM_REGS  per-register write strobe (see Optional Feature).

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: RBCP_ACK=0, RBCP_RD=8'h00, REG_OUT=RESET_VAL, REG_WSTB=0, FSM=IDLE.
- Offset: off = RBCP_ADDR - BASE_ADDR, 32-bit unsigned with wrap. Addresses below BASE_ADDR therefore yield a huge offset and decode as out-of-range.
- Decode regions:
  - RW hit: off < NUM_REGS.
  - RO hit: STAT_OFFSET <= off < STAT_OFFSET+NUM_STAT.
  - Anything else is a miss.
- FSM states: IDLE, DECODE, RESP.
- IDLE:
  - Accepts a strobe only when RBCP_ACT=1 and exactly one of WE/RE is 1.
  - Latches address, WD and direction, then goes to DECODE.
  - WE=RE=1 in the same cycle is illegal: ignored, no ACK, stays IDLE.
  - WE/RE with ACT=0 is ignored.
- DECODE (1 cycle):
  - Write, RW hit: register updated at the end of this cycle.
  - Write, RO hit: accepted and discarded.
  - Read: RBCP_RD loaded from the register or from STAT_IN captured this cycle.
  - Miss: no ACK; return to IDLE. The host sees the SiTCP bus-error timeout.
  - Otherwise go to RESP.
- RESP:
  - RBCP_ACK=1 for exactly one cycle, then IDLE.
  - RBCP_RD returns to 8'h00 on the cycle after ACK, and is 0 on writes.
- Latency: strobe in cycle N, ACK in cycle N+2. REG_OUT changes visibly in cycle N+2.
- RBCP_ACT dropping in DECODE or RESP: abort to IDLE, suppress ACK. A write already committed in DECODE stays committed.
- New strobes arriving while not IDLE are ignored.
- RST asserted mid-access: next cycle FSM=IDLE, ACK=0, registers reloaded to RESET_VAL.
- Back-to-back: a strobe in the cycle right after ACK is accepted, giving 3 cycles per access.

Optional Feature:
- Macro: RBCP_REG_WSTB_EN.
- Defined: REG_WSTB[i] pulses 1 for one cycle, coincident with RBCP_ACK, on every acknowledged write to register i. This includes writes with unchanged data.
- Undefined: REG_WSTB is tied to 0 and no strobe logic is built.

Decomposition:
- Package rbcp_pkg:
  - RBCP_ADDR_W=32, RBCP_DATA_W=8.
  - STAT_OFFSET=32'h80.
  - FSM state typedef {IDLE, DECODE, RESP}.
  - Decode-result typedef {HIT_RW, HIT_RO, MISS}.
- One natural sub-module: rbcp_addr_decode. Combinational; takes the latched address, BASE_ADDR, NUM_REGS and NUM_STAT; returns region and index.

Test Plan:
- Reset-value check: RESET_VAL=16'hA55A with NUM_REGS=2, assert RST 2 cycles -> REG_OUT=16'hA55A, ACK=0, RD=0.
- Write: BASE_ADDR=32'h100, ACT=1, WE pulse, ADDR=32'h103, WD=8'h3C -> ACK exactly 2 cycles later for 1 cycle, REG_OUT[31:24]=8'h3C, other registers unchanged. With the macro, REG_WSTB=16'h0008 in the ACK cycle.
- Read status: STAT_IN byte 2=8'hE7, RE at ADDR=32'h182 -> ACK at +2 with RD=8'hE7, RD=0 the next cycle.
- Misses: RE at ADDR=32'h0FF (wrap) and at 32'h110 -> no ACK within 10 cycles, FSM back to IDLE, registers unchanged.
- Abort and illegal strobes: WE at ADDR=32'h100, ACT dropped in the DECODE cycle -> no ACK, reg0 updated. WE=RE=1 together -> ignored.
- Reset mid-access: RE accepted, RST asserted in the DECODE cycle -> no ACK, REG_OUT=RESET_VAL. A following write at 32'h101 acknowledges normally.

Source files
------------

// File: rtl/rbcp_pkg.sv
// Shared RBCP widths, status window offset and state/decode enums for the
// RBCP register responder.
package rbcp_pkg;

  localparam int RBCP_ADDR_W = 32;
  localparam int RBCP_DATA_W = 8;
  localparam int IDX_W       = 7;

  localparam logic [RBCP_ADDR_W-1:0] STAT_OFFSET = 32'h80;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    HIT_RW,
    HIT_RO,
    MISS
  } decode_e;

endpackage

// File: rtl/rbcp_addr_decode.sv
// Combinational RBCP window decode: classifies a latched address as control
// register, status byte or miss, and returns the index inside that bank.
module rbcp_addr_decode
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                     NUM_REGS  = 16,
  parameter int                     NUM_STAT  = 8
) (
  input  logic [RBCP_ADDR_W-1:0] addr_i,
  output decode_e                region_o,
  output logic [IDX_W-1:0]       index_o
);

  logic [RBCP_ADDR_W-1:0] off;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    off      = addr_i - BASE_ADDR;
    region_o = MISS;
    index_o  = '0;
    if (off < RBCP_ADDR_W'(NUM_REGS)) begin
      region_o = HIT_RW;
      index_o  = off[IDX_W-1:0];
    end else if ((off >= STAT_OFFSET) &&
                 (off < STAT_OFFSET + RBCP_ADDR_W'(NUM_STAT))) begin
      region_o = HIT_RO;
      index_o  = IDX_W'(off - STAT_OFFSET);
    end
  end

endmodule

// File: rtl/rbcp_reg_responder.sv
// RBCP responder: host-writable control bank plus read-only status bytes.
// Define RBCP_REG_WSTB_EN to build the per-register write strobes on REG_WSTB.
module rbcp_reg_responder
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_ADDR_W-1:0]    BASE_ADDR = 32'h0000_0000,
  parameter int                        NUM_REGS  = 16,
  parameter int                        NUM_STAT  = 8,
  parameter logic [NUM_REGS*8-1:0]     RESET_VAL = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         RBCP_ACT,
  input  logic [RBCP_ADDR_W-1:0]       RBCP_ADDR,
  input  logic [RBCP_DATA_W-1:0]       RBCP_WD,
  input  logic                         RBCP_WE,
  input  logic                         RBCP_RE,
  output logic                         RBCP_ACK,
  output logic [RBCP_DATA_W-1:0]       RBCP_RD,
  output logic [NUM_REGS*8-1:0]        REG_OUT,
  input  logic [NUM_STAT*8-1:0]        STAT_IN,
  output logic [NUM_REGS-1:0]          REG_WSTB
);

  state_e                   state_q;
  logic [RBCP_ADDR_W-1:0]   addr_q;
  logic [RBCP_DATA_W-1:0]   wd_q;
  logic                     write_q;
  logic                     ack_q;
  logic [RBCP_DATA_W-1:0]   rd_q;
  logic [NUM_REGS*8-1:0]    reg_q;

  decode_e                  region;
  logic [IDX_W-1:0]         index;
  logic [RBCP_DATA_W-1:0]   rd_d;
  logic                     commit_wr;

  rbcp_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .NUM_STAT  (NUM_STAT)
  ) u_decode (
    .addr_i   (addr_q),
    .region_o (region),
    .index_o  (index)
  );

  assign commit_wr = (state_q == DECODE) && write_q && (region == HIT_RW);

  // Status bytes are sampled here, in the DECODE cycle.
  always_comb begin
    rd_d = '0;
    if (!write_q && region == HIT_RW) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (index == IDX_W'(i)) rd_d = reg_q[i*RBCP_DATA_W +: RBCP_DATA_W];
    end else if (!write_q && region == HIT_RO) begin
      for (int j = 0; j < NUM_STAT; j++)
        if (index == IDX_W'(j)) rd_d = STAT_IN[j*RBCP_DATA_W +: RBCP_DATA_W];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      rd_q    <= '0;
      // NOTE: the control bank is a flop array, so it reloads its image on reset.
      reg_q   <= RESET_VAL;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          rd_q  <= '0;
          if (RBCP_ACT && (RBCP_WE ^ RBCP_RE)) begin
            addr_q  <= RBCP_ADDR;
            wd_q    <= RBCP_WD;
            write_q <= RBCP_WE;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          // The write commits even if ACT drops in this cycle.
          if (commit_wr) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (index == IDX_W'(i)) reg_q[i*RBCP_DATA_W +: RBCP_DATA_W] <= wd_q;
          end
          if (!RBCP_ACT || region == MISS) begin
            state_q <= IDLE;
          end else begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            rd_q    <= rd_d;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          rd_q    <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A host dropping ACT during the response cycle sees no acknowledge.
  assign RBCP_ACK = ack_q & RBCP_ACT;
  assign RBCP_RD  = rd_q;
  assign REG_OUT  = reg_q;

`ifdef RBCP_REG_WSTB_EN
  logic [NUM_REGS-1:0] wstb_q;

  always_ff @(posedge CLK) begin
    if (RST)                        wstb_q <= '0;
    else if (commit_wr && RBCP_ACT) wstb_q <= NUM_REGS'(1) << index;
    else                            wstb_q <= '0;
  end

  assign REG_WSTB = wstb_q & {NUM_REGS{RBCP_ACT}};
`else
  assign REG_WSTB = '0;
`endif

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Self-checking bench for rbcp_reg_responder: directed corner cases followed
// by random accesses scored against a byte-array model of the register map.
module tb_rbcp_reg_responder;

  localparam logic [31:0]  BASE     = 32'h100;
  localparam int           NR       = 16;
  localparam int           NS       = 8;
  localparam logic [31:0]  STAT_OFF = 32'h80;
  localparam logic [127:0] RV       = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

  logic         CLK = 1'b0;
  logic         RST;
  logic         RBCP_ACT;
  logic [31:0]  RBCP_ADDR;
  logic [7:0]   RBCP_WD;
  logic         RBCP_WE;
  logic         RBCP_RE;
  logic         RBCP_ACK;
  logic [7:0]   RBCP_RD;
  logic [127:0] REG_OUT;
  logic [63:0]  STAT_IN;
  logic [15:0]  REG_WSTB;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_regs [NR];
  logic [7:0] ref_stat [NS];

  rbcp_reg_responder #(
    .BASE_ADDR (BASE),
    .NUM_REGS  (NR),
    .NUM_STAT  (NS),
    .RESET_VAL (RV)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RBCP_ACT  (RBCP_ACT),
    .RBCP_ADDR (RBCP_ADDR),
    .RBCP_WD   (RBCP_WD),
    .RBCP_WE   (RBCP_WE),
    .RBCP_RE   (RBCP_RE),
    .RBCP_ACK  (RBCP_ACK),
    .RBCP_RD   (RBCP_RD),
    .REG_OUT   (REG_OUT),
    .STAT_IN   (STAT_IN),
    .REG_WSTB  (REG_WSTB)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_image();
    logic [127:0] img = '0;
    for (int i = 0; i < NR; i++) img[i*8 +: 8] = ref_regs[i];
    return img;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) ref_regs[i] = RV[i*8 +: 8];
  endtask

  task automatic set_stat(input logic [63:0] v);
    STAT_IN = v;
    for (int j = 0; j < NS; j++) ref_stat[j] = v[j*8 +: 8];
  endtask

  task automatic expect_no_ack(input string tag);
    bit saw = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (RBCP_ACK === 1'b1) saw = 1'b1;
    end
    check(tag, saw, 1'b0);
  endtask

  // One full access; called and returns on a falling edge, so a new
  // strobe may be driven right after return (back-to-back).
  task automatic access(input string tag, input logic [31:0] addr, input bit we,
                        input logic [7:0] wd);
    logic [31:0] off;
    bit          rw, ro;
    int          idx;
    logic [7:0]  exp_rd;
    logic [15:0] exp_wstb;
    off    = addr - BASE;
    rw     = off < NR;
    ro     = (off >= STAT_OFF) && (off < STAT_OFF + NS);
    idx    = rw ? int'(off) : ro ? int'(off - STAT_OFF) : 0;
    exp_rd = 8'h00;
    if (!we && rw) exp_rd = ref_regs[idx];
    if (!we && ro) exp_rd = ref_stat[idx];
    exp_wstb = 16'h0000;
`ifdef RBCP_REG_WSTB_EN
    if (we && rw) exp_wstb = 16'(1) << idx;
`endif
    RBCP_ACT  = 1'b1;
    RBCP_ADDR = addr;
    RBCP_WD   = wd;
    RBCP_WE   = we;
    RBCP_RE   = !we;
    @(negedge CLK);
    RBCP_WE = 1'b0;
    RBCP_RE = 1'b0;
    check({tag, "_ack_early"}, RBCP_ACK, 1'b0);
    if (rw || ro) begin
      @(negedge CLK);
      if (we && rw) ref_regs[idx] = wd;
      check({tag, "_ack"}, RBCP_ACK, 1'b1);
      check({tag, "_rd"}, RBCP_RD, exp_rd);
      check({tag, "_wstb"}, REG_WSTB, exp_wstb);
      check({tag, "_regs"}, REG_OUT, model_image());
      @(negedge CLK);
      check({tag, "_ack_after"}, RBCP_ACK, 1'b0);
      check({tag, "_rd_after"}, RBCP_RD, 8'h00);
      check({tag, "_wstb_after"}, REG_WSTB, 16'h0000);
    end else begin
      expect_no_ack({tag, "_miss_noack"});
      check({tag, "_miss_regs"}, REG_OUT, model_image());
    end
  endtask

  initial begin
    logic [31:0] a;
    RST = 1'b1; RBCP_ACT = 1'b0; RBCP_ADDR = '0; RBCP_WD = '0;
    RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    set_stat(64'h0);
    model_reset();

    // Reset state
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("reset_regs", REG_OUT, RV);
    check("reset_ack", RBCP_ACK, 1'b0);
    check("reset_rd", RBCP_RD, 8'h00);
    check("reset_wstb", REG_WSTB, 16'h0000);

    // Basic write, readback and status read
    access("wr103", 32'h103, 1'b1, 8'h3C);
    check("wr103_byte", REG_OUT[31:24], 8'h3C);
    access("rd103", 32'h103, 1'b0, 8'h00);
    set_stat(64'h1122_3344_55E7_6677);
    access("rdstat2", 32'h182, 1'b0, 8'h00);
    access("rdstat7", 32'h187, 1'b0, 8'h00);
    access("wr10f", 32'h10F, 1'b1, 8'h99);
    access("wr_same", 32'h10F, 1'b1, 8'h99);
    access("wr_ro", 32'h180, 1'b1, 8'h77);

    // Misses: wrap below base, gap above RW bank, just past status bank
    access("miss0ff", 32'h0FF, 1'b0, 8'h00);
    access("miss110", 32'h110, 1'b0, 8'h00);
    access("miss188", 32'h188, 1'b1, 8'h55);

    // ACT dropped in DECODE: no ACK, write still committed
    RBCP_ACT = 1'b1; RBCP_ADDR = 32'h100; RBCP_WD = 8'hC3; RBCP_WE = 1'b1;
    @(negedge CLK);
    RBCP_WE = 1'b0; RBCP_ACT = 1'b0;
    ref_regs[0] = 8'hC3;
    expect_no_ack("abort_noack");
    check("abort_regs", REG_OUT, model_image());

    // Illegal WE+RE together, and strobe with ACT low
    RBCP_ACT = 1'b1; RBCP_ADDR = 32'h104; RBCP_WD = 8'hEE;
    RBCP_WE = 1'b1; RBCP_RE = 1'b1;
    @(negedge CLK);
    RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    expect_no_ack("both_noack");
    check("both_regs", REG_OUT, model_image());
    RBCP_ACT = 1'b0; RBCP_WE = 1'b1;
    @(negedge CLK);
    RBCP_WE = 1'b0; RBCP_ACT = 1'b1;
    expect_no_ack("noact_noack");
    check("noact_regs", REG_OUT, model_image());

    // Reset during DECODE of a read
    RBCP_ACT = 1'b1; RBCP_ADDR = 32'h103; RBCP_RE = 1'b1;
    @(negedge CLK);
    RBCP_RE = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    check("rstmid_ack", RBCP_ACK, 1'b0);
    check("rstmid_regs", REG_OUT, RV);
    expect_no_ack("rstmid_noack");
    access("after_rst", 32'h101, 1'b1, 8'h5A);

    // Back-to-back accesses, one strobe right after each ACK
    access("b2b_a", 32'h105, 1'b1, 8'h01);
    access("b2b_b", 32'h105, 1'b0, 8'h00);
    access("b2b_c", 32'h184, 1'b0, 8'h00);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      set_stat({$urandom, $urandom});
      case ($urandom_range(0, 4))
        0, 1: a = BASE + 32'($urandom_range(0, NR - 1));
        2:    a = BASE + STAT_OFF + 32'($urandom_range(0, NS - 1));
        3:    a = 32'($urandom_range(0, 255));
        default: a = BASE + 32'($urandom_range(NR, 32'h7F));
      endcase
      access("rnd", a, 1'($urandom_range(0, 1)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        RBCP_ACT = 1'b0;
        @(negedge CLK);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
